// File: rtl/ram_port_arbiter.sv
// Grants one fetch (I) or load/store (D) request per cycle onto a single-port big-endian word RAM.
// Define RAM_ARB_RR_EN to replace fixed D-over-I priority with round-robin arbitration.
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  i_req_i,
   input  logic [ADDR_WIDTH-1:0] i_addr_i,
   output logic                  i_gnt_o,
   output logic                  i_rvalid_o,
   output logic [DATA_WIDTH-1:0] i_rdata_o,
   input  logic                  d_req_i,
   input  logic                  d_we_i,
   input  logic [1:0]            d_size_i,
   input  logic [ADDR_WIDTH-1:0] d_addr_i,
   input  logic [DATA_WIDTH-1:0] d_wdata_i,
   output logic                  d_gnt_o,
   output logic                  d_rvalid_o,
   output logic [DATA_WIDTH-1:0] d_rdata_o,
   output logic                  d_err_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_data_o,
   input  logic [DATA_WIDTH-1:0] ram_data_i
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_RMW_WR = 1'b1;
   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         2'b00:   bad = 1'b0;
         2'b01:   bad = off[0];
         2'b10:   bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Big-endian lane merge: offset 0 is the most significant byte/half.
   function automatic logic [DATA_WIDTH-1:0] merge_word(input logic [DATA_WIDTH-1:0] old,
                                                        input logic [15:0] wdata,
                                                        input logic [1:0] off,
                                                        input logic [1:0] size);
      logic [DATA_WIDTH-1:0] w;
      w = old;
      if (size == 2'b00) begin
         case (off)
            2'b00:   w[31:24] = wdata[7:0];
            2'b01:   w[23:16] = wdata[7:0];
            2'b10:   w[15:8]  = wdata[7:0];
            default: w[7:0]   = wdata[7:0];
         endcase
      end else if (off[1]) begin
         w[15:0] = wdata;
      end else begin
         w[31:16] = wdata;
      end
      return w;
   endfunction

   logic [0:0]            state_r;
   logic [ADDR_WIDTH-1:0] rmw_addr_r;
   logic [DATA_WIDTH-1:0] rmw_data_r;
   logic                  i_rvalid_r;
   logic [DATA_WIDTH-1:0] i_rdata_r;
   logic                  d_rvalid_r;
   logic [DATA_WIDTH-1:0] d_rdata_r;
   logic                  d_err_r;
   logic                  pick_d_s;
   logic                  i_gnt_s;
   logic                  d_gnt_s;
   logic                  d_err_s;
   logic                  d_sub_s;
   logic                  ram_we_s;
   logic [ADDR_WIDTH-1:0] ram_addr_s;
   logic [DATA_WIDTH-1:0] ram_data_s;

`ifdef RAM_ARB_RR_EN
   logic last_d_r;

   // Round-robin: on a conflict the port that was not granted last wins.
   always_comb begin
      pick_d_s = d_req_i & ~(i_req_i & last_d_r);
   end

   // Remember which port took the most recent grant.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_d_r <= 1'b0;
      end else if (d_gnt_s) begin
         last_d_r <= 1'b1;
      end else if (i_gnt_s) begin
         last_d_r <= 1'b0;
      end
   end
`else
   assign pick_d_s = d_req_i;
`endif

   assign d_err_s = is_misaligned(d_size_i, d_addr_i[1:0]);
   assign d_sub_s = d_we_i & ~d_err_s & (d_size_i != 2'b10);

   // Grants are only issued from IDLE and never while reset is asserted.
   always_comb begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
      if (rst_n_i && (state_r == ST_IDLE)) begin
         d_gnt_s = pick_d_s;
         i_gnt_s = i_req_i & ~pick_d_s;
      end else begin
         i_gnt_s = 1'b0;
         d_gnt_s = 1'b0;
      end
   end

   // RAM address/write steering for the granted request or the pending merged write.
   always_comb begin
      ram_we_s   = 1'b0;
      ram_addr_s = {ADDR_WIDTH{1'b0}};
      ram_data_s = {DATA_WIDTH{1'b0}};
      if (state_r == ST_RMW_WR) begin
         ram_we_s   = 1'b1;
         ram_addr_s = rmw_addr_r;
         ram_data_s = rmw_data_r;
      end else if (d_gnt_s) begin
         ram_addr_s = d_addr_i & WORD_MASK;
         if (d_we_i && !d_err_s && (d_size_i == 2'b10)) begin
            ram_we_s   = 1'b1;
            ram_data_s = d_wdata_i;
         end else begin
            ram_we_s   = 1'b0;
         end
      end else if (i_gnt_s) begin
         ram_addr_s = i_addr_i & WORD_MASK;
      end else begin
         ram_we_s = 1'b0;
      end
   end

   // FSM and registered responses.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r    <= ST_IDLE;
         rmw_addr_r <= {ADDR_WIDTH{1'b0}};
         rmw_data_r <= {DATA_WIDTH{1'b0}};
         i_rvalid_r <= 1'b0;
         i_rdata_r  <= {DATA_WIDTH{1'b0}};
         d_rvalid_r <= 1'b0;
         d_rdata_r  <= {DATA_WIDTH{1'b0}};
         d_err_r    <= 1'b0;
      end else begin
         i_rvalid_r <= i_gnt_s;
         if (i_gnt_s) begin
            i_rdata_r <= ram_data_i;
         end
         d_rvalid_r <= 1'b0;
         d_err_r    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (d_gnt_s && d_sub_s) begin
                  state_r    <= ST_RMW_WR;
                  rmw_addr_r <= d_addr_i & WORD_MASK;
                  rmw_data_r <= merge_word(ram_data_i, d_wdata_i[15:0], d_addr_i[1:0], d_size_i);
               end else if (d_gnt_s) begin
                  d_rvalid_r <= 1'b1;
                  d_err_r    <= d_err_s;
                  d_rdata_r  <= (d_we_i || d_err_s) ? {DATA_WIDTH{1'b0}} : ram_data_i;
               end
            end
            ST_RMW_WR: begin
               state_r    <= ST_IDLE;
               d_rvalid_r <= 1'b1;
               d_rdata_r  <= {DATA_WIDTH{1'b0}};
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign i_gnt_o    = i_gnt_s;
   assign d_gnt_o    = d_gnt_s;
   assign i_rvalid_o = i_rvalid_r;
   assign i_rdata_o  = i_rdata_r;
   assign d_rvalid_o = d_rvalid_r;
   assign d_rdata_o  = d_rdata_r;
   assign d_err_o    = d_err_r;
   assign ram_we_o   = ram_we_s;
   assign ram_addr_o = ram_addr_s;
   assign ram_data_o = ram_data_s;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a byte-lane RAM reference model predicts grants, responses and writes.
module tb_ram_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        i_req_i, i_gnt_o, i_rvalid_o;
   logic [31:0] i_addr_i, i_rdata_o;
   logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o, d_err_o;
   logic [1:0]  d_size_i;
   logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
   logic        ram_we_o;
   logic [31:0] ram_addr_o, ram_data_o, ram_data_i;

   always #5 clk_i = ~clk_i;

   ram_port_arbiter dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
      .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
      .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
      .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
      .ram_data_i(ram_data_i)
   );

   // RAM instance stand-in: combinational read, synchronous full-word write.
   logic [31:0] mem [256] = '{default: 32'h0};
   assign ram_data_i = mem[ram_addr_o[9:2]];
   always @(posedge clk_i) if (ram_we_o) mem[ram_addr_o[9:2]] <= ram_data_o;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct { int cyc; logic [31:0] data; logic err; } rsp_t;
   typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wr_t;
   rsp_t iq[$];
   rsp_t dq[$];
   wr_t  wq[$];

   bit [31:0] ref_mem [256];
   bit        last_d = 1'b0;
   int        blocked = -1;
   bit        mon_en = 1'b0;
   int        checks = 0;
   int        errors = 0;

   bit          ip = 1'b0, dp = 1'b0, dwe = 1'b0;
   logic [31:0] ia = 32'h0, da = 32'h0, dw = 32'h0;
   logic [1:0]  dsz = 2'b00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference semantics of one accepted D request, computed with lane arithmetic.
   task automatic model_d();
      int        o = int'(da[1:0]);
      bit        err = (dsz == 2'd3) || (dsz == 2'd1 && (o % 2) == 1) || (dsz == 2'd2 && o != 0);
      int        shift;
      bit [31:0] mask;
      bit [31:0] nw;
      if (err) begin
         dq.push_back('{cyc: cyc + 1, data: 32'h0, err: 1'b1});
      end else if (!dwe) begin
         dq.push_back('{cyc: cyc + 1, data: ref_mem[da[9:2]], err: 1'b0});
      end else if (dsz == 2'd2) begin
         ref_mem[da[9:2]] = dw;
         wq.push_back('{cyc: cyc, addr: {da[31:2], 2'b00}, data: dw});
         dq.push_back('{cyc: cyc + 1, data: 32'h0, err: 1'b0});
      end else begin
         shift = (dsz == 2'd0) ? (3 - o) * 8 : (2 - o) * 8;
         mask  = (dsz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
         nw    = (ref_mem[da[9:2]] & ~(mask << shift)) | ((dw & mask) << shift);
         ref_mem[da[9:2]] = nw;
         wq.push_back('{cyc: cyc + 1, addr: {da[31:2], 2'b00}, data: nw});
         dq.push_back('{cyc: cyc + 2, data: 32'h0, err: 1'b0});
         blocked = cyc + 1;
      end
   endtask

   // One cycle of stimulus: drive pending requests, predict and check grants.
   task automatic step();
      bit gi, gd;
      @(negedge clk_i);
      i_req_i = ip; i_addr_i = ia;
      d_req_i = dp; d_we_i = dwe; d_size_i = dsz; d_addr_i = da; d_wdata_i = dw;
      #1;
      gi = 1'b0; gd = 1'b0;
      if (cyc != blocked) begin
`ifdef RAM_ARB_RR_EN
         if (dp && ip) begin gd = !last_d; gi = last_d; end
         else begin gd = dp; gi = ip; end
`else
         gd = dp; gi = ip && !dp;
`endif
      end
      chk("d_gnt", d_gnt_o, gd);
      chk("i_gnt", i_gnt_o, gi);
      if (gd) begin
`ifdef RAM_ARB_RR_EN
         last_d = 1'b1;
`endif
         chk("ram_addr_d", ram_addr_o, {da[31:2], 2'b00});
         model_d();
         dp = 1'b0;
      end else if (gi) begin
`ifdef RAM_ARB_RR_EN
         last_d = 1'b0;
`endif
         chk("ram_addr_i", ram_addr_o, {ia[31:2], 2'b00});
         iq.push_back('{cyc: cyc + 1, data: ref_mem[ia[9:2]], err: 1'b0});
         ip = 1'b0;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && (ip || dp); k++) step();
      chk("drain_pending", {30'h0, ip, dp}, 32'h0);
      repeat (3) step();
   endtask

   task automatic dreq(input bit we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w);
      dp = 1'b1; dwe = we; dsz = sz; da = a; dw = w;
      step();
   endtask

   // Scoreboard monitor: every cycle, compare outputs against the front of each queue.
   always @(negedge clk_i) begin
      rsp_t e;
      wr_t  w;
      bit   ev;
      #2;
      if (mon_en) begin
         ev = (iq.size() > 0) && (iq[0].cyc == cyc);
         chk("i_rvalid", i_rvalid_o, ev);
         if (ev) begin
            e = iq.pop_front();
            chk("i_rdata", i_rdata_o, e.data);
         end
         ev = (dq.size() > 0) && (dq[0].cyc == cyc);
         chk("d_rvalid", d_rvalid_o, ev);
         if (ev) begin
            e = dq.pop_front();
            chk("d_rdata", d_rdata_o, e.data);
            chk("d_err", d_err_o, e.err);
         end
         ev = (wq.size() > 0) && (wq[0].cyc == cyc);
         chk("ram_we", ram_we_o, ev);
         if (ev) begin
            w = wq.pop_front();
            chk("ram_waddr", ram_addr_o, w.addr);
            chk("ram_wdata", ram_data_o, w.data);
         end
      end
   end

   initial begin
      logic [1:0] r;
      rst_n_i = 1'b0;
      i_req_i = 1'b0; i_addr_i = 32'h0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_size_i = 2'b00; d_addr_i = 32'h0; d_wdata_i = 32'h0;
      repeat (3) @(negedge clk_i);
      #1;
      chk("rst_i_gnt", i_gnt_o, 32'h0);
      chk("rst_d_gnt", d_gnt_o, 32'h0);
      chk("rst_i_rvalid", i_rvalid_o, 32'h0);
      chk("rst_i_rdata", i_rdata_o, 32'h0);
      chk("rst_d_rvalid", d_rvalid_o, 32'h0);
      chk("rst_d_rdata", d_rdata_o, 32'h0);
      chk("rst_d_err", d_err_o, 32'h0);
      chk("rst_ram_we", ram_we_o, 32'h0);
      chk("rst_ram_addr", ram_addr_o, 32'h0);
      chk("rst_ram_data", ram_data_o, 32'h0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      mon_en = 1'b1;

      // Fetch of a preloaded word with unaligned low address bits.
      dreq(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
      drain();
      ip = 1'b1; ia = 32'h102;
      step();
      drain();

      // Byte and half RMW stores, then a misaligned half.
      dreq(1'b1, 2'd2, 32'h100, 32'h11223344);
      dreq(1'b1, 2'd0, 32'h101, 32'h000000AB);
      drain();
      chk("mem_0x100_byte", mem[64], 32'h11AB3344);
      dreq(1'b1, 2'd2, 32'h200, 32'hAABBCCDD);
      dreq(1'b1, 2'd1, 32'h202, 32'h00001234);
      drain();
      chk("mem_0x200_half", mem[128], 32'hAABB1234);
      dreq(1'b1, 2'd1, 32'h203, 32'h00005678);
      drain();
      chk("mem_0x200_after_err", mem[128], 32'hAABB1234);

      // Four cycles of simultaneous load requests.
      for (int k = 0; k < 4; k++) begin
         if (!ip) begin ip = 1'b1; ia = 32'h100; end
         if (!dp) begin dp = 1'b1; dwe = 1'b0; dsz = 2'd2; da = 32'h200; end
         step();
      end
      drain();

      // Back-to-back word stores.
      dreq(1'b1, 2'd2, 32'h10, 32'hCAFE0010);
      dreq(1'b1, 2'd2, 32'h14, 32'hCAFE0014);
      drain();

      // Reset asserted while the merged write is on the RAM port.
      mon_en = 1'b0;
      @(negedge clk_i);
      d_req_i = 1'b1; d_we_i = 1'b1; d_size_i = 2'd0; d_addr_i = 32'h102; d_wdata_i = 32'h55;
      #1 chk("abort_gnt", d_gnt_o, 32'h1);
      @(negedge clk_i);
      d_req_i = 1'b0;
      #1 chk("abort_we_before", ram_we_o, 32'h1);
      rst_n_i = 1'b0;
      #1 chk("abort_we_dropped", ram_we_o, 32'h0);
      @(negedge clk_i);
      #1 chk("abort_no_rvalid_rst", d_rvalid_o, 32'h0);
      rst_n_i = 1'b1;
      last_d = 1'b0;
      blocked = -1;
      @(negedge clk_i);
      #1 chk("abort_no_rvalid", d_rvalid_o, 32'h0);
      chk("abort_mem", mem[64], 32'h11AB3344);
      mon_en = 1'b1;
      dreq(1'b0, 2'd2, 32'h100, 32'h0);
      drain();

      // Randomised traffic.
      for (int n = 0; n < 800; n++) begin
         if (!ip && ($urandom % 3) == 0) begin
            ip = 1'b1; ia = $urandom_range(0, 1023);
         end
         if (!dp && ($urandom % 2) == 0) begin
            dp  = 1'b1;
            dwe = 1'($urandom % 2);
            r   = 2'($urandom % 8);
            dsz = (r < 2'd3) ? 2'd0 : 2'($urandom % 4);
            da  = $urandom_range(0, 1023);
            if (($urandom % 2) == 0)
               da = (dsz == 2'd1) ? (da & 32'hFFFF_FFFE) : ((dsz == 2'd2) ? (da & 32'hFFFF_FFFC) : da);
            dw = $urandom;
         end
         step();
      end
      drain();

      chk("iq_empty", iq.size(), 32'h0);
      chk("dq_empty", dq.size(), 32'h0);
      chk("wq_empty", wq.size(), 32'h0);
      for (int i = 0; i < 256; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
